// File: rtl/smg_pkg.sv
// smg_pkg: segment encodings, BCD-to-segment lookup and conversion FSM states
// shared by the 7-segment scan controller.
package smg_pkg;

  // Active-high {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {IDLE, CONV, CHECK} conv_state_e;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // ceil(bin_w * log10(2)) plus one spare digit
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/smg_bin2bcd.sv
// smg_bin2bcd: sequential double-dabble converter, one add-3/shift step per
// clock; done pulses for one cycle after the last step.
module smg_bin2bcd
  import smg_pkg::*;
#(
  parameter int BIN_W = 20,
  parameter int N_BCD = bcd_digits(BIN_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic [4*N_BCD-1:0] bcd
);
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * N_BCD;

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < N_BCD; i++) begin
      if (bcd_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      // spare top digit never exceeds 7, so its MSB is safely dropped
      bcd_d = BCD_W'({adj, bin_q[BIN_W-1]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      bin_d  = bin;
      bcd_d  = '0;
      cnt_d  = CW'(BIN_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/smg_scan_ctrl.sv
// smg_scan_ctrl: multiplexed 7-segment driver with sequential BCD conversion.
// Define SMG_BLINK_EN to add the blink_mask port and a ~2 Hz per-digit blink.
//   state | meaning
//   IDLE  | val_ready high, waiting for a value
//   CONV  | double-dabble running in smg_bin2bcd
//   CHECK | overflow test, display register and ovf load on exit
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int BIN_W      = 20,
  parameter int CLK_HZ     = 50000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLANK_CYC  = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                val_valid,
  input  logic [BIN_W-1:0]    val_bin,
  output logic                val_ready,
  input  logic                lz_en,
  input  logic [N_DIGITS-1:0] dp_mask,
`ifdef SMG_BLINK_EN
  input  logic [N_DIGITS-1:0] blink_mask,
`endif
  output logic                ovf,
  output logic [7:0]          SMG_Data,
  output logic [N_DIGITS-1:0] Scan_Sig
);
  localparam int   P     = CLK_HZ / (SCAN_HZ * N_DIGITS);
  localparam int   PW    = (P > 1) ? $clog2(P) : 1;
  localparam int   IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int   NBCD  = bcd_digits(BIN_W);
  localparam int   NX    = (NBCD > N_DIGITS) ? NBCD : N_DIGITS;
  localparam logic INV   = (ACTIVE_LOW != 0);

  if (P <= BLANK_CYC) begin : g_bad_period
    $error("smg_scan_ctrl: slot period %0d must exceed BLANK_CYC %0d", P, BLANK_CYC);
  end
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
    $error("smg_scan_ctrl: N_DIGITS %0d outside 1..8", N_DIGITS);
  end

  conv_state_e           state_q, state_d;
  logic                  accept, conv_start, conv_busy, conv_done, load_disp;
  logic [4*NBCD-1:0]     conv_bcd;
  logic [4*NX-1:0]       bcd_ext;
  logic                  ovf_calc, ovf_q, ovf_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  slot_end, lit, nz_seen;
  logic [N_DIGITS-1:0]   lz_blank, scan_act, scan_q, scan_d;
  logic [7:0]            seg_nxt, pat_q, pat_d, seg_q, seg_d;

  smg_bin2bcd #(.BIN_W(BIN_W), .N_BCD(NBCD)) u_bin2bcd (
    .clk   (CLK),
    .rst_n (RSTn),
    .start (conv_start),
    .bin   (val_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (conv_done) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    val_ready  = (state_q == IDLE);
    accept     = val_valid && val_ready;
    conv_start = accept && !conv_busy;
    load_disp  = (state_q == CHECK);
  end

  always_comb begin
    bcd_ext = '0;
    bcd_ext[4*NBCD-1:0] = conv_bcd;
    ovf_calc = 1'b0;
    for (int i = N_DIGITS; i < NX; i++) ovf_calc = ovf_calc | (bcd_ext[4*i +: 4] != 4'd0);
    disp_d = load_disp ? bcd_ext[4*N_DIGITS-1:0] : disp_q;
    ovf_d  = load_disp ? ovf_calc : ovf_q;
  end

  always_comb begin
    slot_end = (presc_q == PW'(P - 1));
    presc_d  = slot_end ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

`ifdef SMG_BLINK_EN
  // Phase flips every SCAN_HZ/4 frames, i.e. a ~2 Hz on/off cycle
  localparam int BLINK_FR = (SCAN_HZ / 4 > 0) ? SCAN_HZ / 4 : 1;
  localparam int BCW      = $clog2(BLINK_FR + 1);
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           blink_off_q, blink_off_d;

  always_comb begin
    bcnt_d      = bcnt_q;
    blink_off_d = blink_off_q;
    if (slot_end && idx_q == IDX_W'(N_DIGITS - 1)) begin
      if (bcnt_q == '0) begin
        bcnt_d      = BCW'(BLINK_FR - 1);
        blink_off_d = !blink_off_q;
      end else begin
        bcnt_d = bcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bcnt_q      <= BCW'(BLINK_FR - 1);
      blink_off_q <= 1'b0;
    end else begin
      bcnt_q      <= bcnt_d;
      blink_off_q <= blink_off_d;
    end
  end
`endif

  always_comb begin
    nz_seen  = 1'b0;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nz_seen     = nz_seen | (disp_q[4*i +: 4] != 4'd0);
      lz_blank[i] = !nz_seen && (i != 0);
    end
    seg_nxt = bcd_to_seg(disp_q[4*idx_q +: 4]);
    if (ovf_q) seg_nxt = SEG_DASH;
    else if (lz_en && lz_blank[idx_q]) seg_nxt = SEG_BLANK;
    seg_nxt[7] = dp_mask[idx_q];
`ifdef SMG_BLINK_EN
    if (blink_off_q && blink_mask[idx_q]) seg_nxt = SEG_BLANK;
`endif
    // pattern frozen at slot start so a display update cannot tear a lit digit
    pat_d    = (presc_q == '0) ? seg_nxt : pat_q;
    lit      = (presc_q >= PW'(BLANK_CYC));
    scan_act = '0;
    scan_act[idx_q] = 1'b1;
    seg_d  = (lit ? pat_q : SEG_BLANK) ^ {8{INV}};
    scan_d = (lit ? scan_act : '0) ^ {N_DIGITS{INV}};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      pat_q   <= SEG_BLANK;
      seg_q   <= {8{INV}};
      scan_q  <= {N_DIGITS{INV}};
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      seg_q   <= seg_d;
      scan_q  <= scan_d;
    end
  end

  assign ovf      = ovf_q;
  assign SMG_Data = seg_q;
  assign Scan_Sig = scan_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// tb_smg_scan_ctrl: scoreboard bench for smg_scan_ctrl (N=6, 20-bit, P=10 cycles/slot).
module tb_smg_scan_ctrl;
  localparam int N   = 6;
  localparam int BW  = 20;
  localparam int LAT = BW + 2;
  localparam int P   = 10;
  localparam int BL  = 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          val_valid = 1'b0;
  logic [BW-1:0] val_bin = '0;
  logic          lz_en = 1'b0;
  logic [N-1:0]  dp_mask = '0;
  logic          val_ready, ovf;
  logic [7:0]    SMG_Data;
  logic [N-1:0]  Scan_Sig;
`ifdef SMG_BLINK_EN
  logic [N-1:0]  blink_mask = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic mon_busy = 1'b0;

  typedef struct {
    logic         eovf;
    logic [8*N-1:0] pats;
    int           acc;
  } exp_t;
  exp_t sb[$];

  smg_scan_ctrl #(
    .N_DIGITS(N), .BIN_W(BW), .CLK_HZ(6000), .SCAN_HZ(100), .BLANK_CYC(BL), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .val_valid(val_valid), .val_bin(val_bin), .val_ready(val_ready),
    .lz_en(lz_en), .dp_mask(dp_mask),
`ifdef SMG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .ovf(ovf), .SMG_Data(SMG_Data), .Scan_Sig(Scan_Sig)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // -1: all digits off, -2: not one-hot, else active digit index
  function automatic int onehot_idx(input logic [N-1:0] s);
    logic [N-1:0] a;
    a = ~s;
    if (a == '0) return -1;
    for (int i = 0; i < N; i++) if (a == (N'(1) << i)) return i;
    return -2;
  endfunction

  // Monitor: each conversion completion is matched against the scoreboard
  initial begin : monitor
    logic prev_rdy;
    exp_t e;
    logic [7:0] got [N];
    int c;
    prev_rdy = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_rdy = 1'b1;
        continue;
      end
      if (val_ready && !prev_rdy) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: conversion finished with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'(LAT));
          chk("ovf", 64'(ovf), 64'(e.eovf));
          repeat (2 * P) @(negedge CLK);
          for (int i = 0; i < N; i++) got[i] = 'x;
          repeat (N * P + P) begin
            @(negedge CLK);
            c = onehot_idx(Scan_Sig);
            if (c >= 0) got[c] = SMG_Data;
          end
          for (int i = 0; i < N; i++)
            chk($sformatf("digit%0d", i), 64'(got[i]), 64'(e.pats[8*i +: 8]));
        end
        mon_busy = 1'b0;
      end
      prev_rdy = val_ready;
    end
  end

  // Slot timing: BL all-off cycles, then P-BL cycles of one digit, order 0..N-1
  initial begin : scan_chk
    int blank_run, lit_run, last_idx, cur;
    logic first;
    blank_run = 0; lit_run = 0; last_idx = N - 1; first = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        blank_run = 0; lit_run = 0; last_idx = N - 1; first = 1'b1;
        continue;
      end
      cur = onehot_idx(Scan_Sig);
      if (cur == -1) begin
        if (lit_run > 0) begin
          chk("lit_len", 64'(lit_run), 64'(P - BL));
          lit_run = 0;
          blank_run = 0;
        end
        chk("blank_seg", 64'(SMG_Data), 64'hFF);
        blank_run++;
      end else if (lit_run == 0) begin
        if (!first) chk("blank_len", 64'(blank_run), 64'(BL));
        chk("scan_order", 64'(cur), 64'((last_idx + 1) % N));
        first = 1'b0;
        last_idx = cur;
        lit_run = 1;
      end else begin
        chk("scan_stable", 64'(cur), 64'(last_idx));
        lit_run++;
      end
    end
  end

  task automatic load(input logic [BW-1:0] v, input logic lz, input logic [N-1:0] dp,
                      input logic push, input logic glitch,
                      input logic eo, input logic [8*N-1:0] ep);
    exp_t e;
    chk("ready_idle", 64'(val_ready), 64'd1);
    lz_en = lz;
    dp_mask = dp;
    val_bin = v;
    val_valid = 1'b1;
    @(posedge CLK);
    #1;
    val_valid = 1'b0;
    val_bin = '0;
    e.eovf = eo;
    e.pats = ep;
    e.acc = cyc;
    if (push) sb.push_back(e);
    chk("ready_drop", 64'(val_ready), 64'd0);
    if (glitch) begin
      repeat (2) @(posedge CLK);
      #1;
      val_valid = 1'b1;
      val_bin = 20'd777;
      @(posedge CLK);
      #1;
      val_valid = 1'b0;
      val_bin = '0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (t < 400) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0 && !mon_busy) break;
      t++;
    end
    if (t >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: scoreboard not drained, %0d entries left", sb.size());
    end
    @(negedge CLK);
    #1;
  endtask

  int off_n = 0, on_n = 0, other_bad = 0;

  initial begin : stim
    repeat (3) @(negedge CLK);
    chk("rst_seg", 64'(SMG_Data), 64'hFF);
    chk("rst_scan", 64'(Scan_Sig), 64'h3F);
    chk("rst_ready", 64'(val_ready), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    RSTn = 1'b1;
    repeat (25) @(negedge CLK);
    #1;

    load(20'd1234, 1'b1, 6'b0, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99});
    wait_idle();
    load(20'd1000000, 1'b1, 6'b0, 1'b1, 1'b0, 1'b1, {6{8'hBF}});
    wait_idle();
    load(20'd999999, 1'b1, 6'b0, 1'b1, 1'b0, 1'b0, {6{8'h90}});
    wait_idle();
    load(20'd5, 1'b0, 6'b000010, 1'b1, 1'b0, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h92});
    wait_idle();
    load(20'd42, 1'b1, 6'b0, 1'b1, 1'b1, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});
    wait_idle();
    load(20'd1000000, 1'b0, 6'b0, 1'b1, 1'b0, 1'b1, {6{8'hBF}});
    wait_idle();

    // reset in the middle of a conversion while ovf is set
    load(20'd123, 1'b1, 6'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (8) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    chk("midrst_seg", 64'(SMG_Data), 64'hFF);
    chk("midrst_scan", 64'(Scan_Sig), 64'h3F);
    chk("midrst_ready", 64'(val_ready), 64'd1);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    #1;

    load(20'd0, 1'b1, 6'b0, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    wait_idle();
    load(20'd42, 1'b1, 6'b0, 1'b1, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4});
    wait_idle();

`ifdef SMG_BLINK_EN
    blink_mask = 6'b000001;
    repeat (3300) begin
      @(negedge CLK);
      if (onehot_idx(Scan_Sig) == 0) begin
        if (SMG_Data == 8'hFF) off_n++;
        else if (SMG_Data == 8'hA4) on_n++;
      end
      if (onehot_idx(Scan_Sig) == 1 && SMG_Data != 8'h99) other_bad++;
    end
    chk("blink_off_seen", 64'(off_n > 0), 64'd1);
    chk("blink_on_seen", 64'(on_n > 0), 64'd1);
    chk("blink_other", 64'(other_bad), 64'd0);
    blink_mask = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
